// File: rtl/enc_bundler_acc_pkg.sv
// Shared encoder constants and the bundler state type used by enc_bundler_acc.
package enc_bundler_acc_pkg;

    localparam int HV_DIM          = 1024;
    localparam int FEATURES_PER_CC = 4;
    localparam int NUM_PACKS       = 10;
    localparam int CNT_W           = 8;
    localparam int THRESHOLD       = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } enc_bund_state_t;

endpackage

// File: rtl/enc_bundler_acc_lane_popcount.sv
// enc_lane_popcount: combinational count of set bits across LANES inputs.
// Only present when ENC_BUNDLE_THRESH_EN is defined.
`ifdef ENC_BUNDLE_THRESH_EN
module enc_lane_popcount #(
    parameter int LANES = 2,
    parameter int POP_W = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0] bits,
    output logic [POP_W-1:0] count
);

    // Sum the lane bits for this hypervector position.
    always_comb begin
        count = '0;
        for (int l = 0; l < LANES; l++) begin
            count = count + POP_W'(bits[l]);
        end
    end

endmodule
`endif

// File: rtl/enc_bundler_acc.sv
// enc_bundler_acc: folds NUM_PACKS beats of bound hypervectors into one bundled
// hypervector. OR bundling by default; ENC_BUNDLE_THRESH_EN selects per-bit
// saturating vote counters compared against THRESHOLD.
module enc_bundler_acc #(
    parameter int HV_DIM    = enc_bundler_acc_pkg::HV_DIM,
    parameter int LANES     = enc_bundler_acc_pkg::FEATURES_PER_CC / 2,
    parameter int NUM_PACKS = enc_bundler_acc_pkg::NUM_PACKS
`ifdef ENC_BUNDLE_THRESH_EN
    ,
    parameter int CNT_W     = enc_bundler_acc_pkg::CNT_W,
    parameter int THRESHOLD = enc_bundler_acc_pkg::THRESHOLD
`endif
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start_encoding,
    input  logic              in_valid,
    input  logic [HV_DIM-1:0] shifted_hv [0:LANES-1],
    output logic              out_valid,
    input  logic              out_ready,
    output logic [HV_DIM-1:0] bundled_hv,
    output logic              busy
);
    import enc_bundler_acc_pkg::*;

    localparam int PC_W = (NUM_PACKS > 1) ? $clog2(NUM_PACKS) : 1;
    localparam logic [PC_W-1:0] LAST_PACK = PC_W'(NUM_PACKS - 1);

    enc_bund_state_t   state_r;
    enc_bund_state_t   state_nx_s;
    logic [PC_W-1:0]   pack_cnt_r;
    logic [HV_DIM-1:0] bundled_r;
    logic [HV_DIM-1:0] result_s;
    logic              out_valid_r;
    logic              busy_r;
    logic              clear_s;
    logic              fold_s;
    logic              last_s;

    // Next-state and datapath strobes; a start in DONE with out_ready restarts at once.
    always_comb begin
        state_nx_s = state_r;
        clear_s    = 1'b0;
        fold_s     = 1'b0;
        last_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_encoding) begin
                    state_nx_s = ACCUM;
                    clear_s    = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    fold_s = 1'b1;
                    if (pack_cnt_r == LAST_PACK) begin
                        last_s     = 1'b1;
                        state_nx_s = DONE;
                    end else begin
                        state_nx_s = ACCUM;
                    end
                end else begin
                    state_nx_s = ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (start_encoding) begin
                        state_nx_s = ACCUM;
                        clear_s    = 1'b1;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, pack counter, result and handshake flags.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_r     <= IDLE;
            pack_cnt_r  <= '0;
            bundled_r   <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            out_valid_r <= (state_nx_s == DONE);
            busy_r      <= (state_nx_s != IDLE);
            if (clear_s || last_s) begin
                pack_cnt_r <= '0;
            end else if (fold_s) begin
                pack_cnt_r <= pack_cnt_r + PC_W'(1);
            end else begin
                pack_cnt_r <= pack_cnt_r;
            end
            if (last_s) begin
                bundled_r <= result_s;
            end else begin
                bundled_r <= bundled_r;
            end
        end
    end

`ifdef ENC_BUNDLE_THRESH_EN
    localparam int POP_W = $clog2(LANES + 1);
    localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [SUM_W-1:0] sum);
        if (sum > SUM_W'(CNT_MAX)) begin
            return CNT_MAX;
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    for (genvar b = 0; b < HV_DIM; b++) begin : g_bit
        logic [LANES-1:0] lane_bits_s;
        logic [POP_W-1:0] pop_s;
        logic [SUM_W-1:0] sum_s;
        logic [CNT_W-1:0] cnt_r;

        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign lane_bits_s[l] = shifted_hv[l][b];
        end

        enc_lane_popcount #(
            .LANES (LANES),
            .POP_W (POP_W)
        ) u_pop (
            .bits  (lane_bits_s),
            .count (pop_s)
        );

        // The vote includes the current beat, so the last beat needs no extra cycle.
        assign sum_s       = SUM_W'(cnt_r) + SUM_W'(pop_s);
        assign result_s[b] = (sum_s >= SUM_W'(THRESHOLD));

        // Saturating per-bit vote counter.
        always_ff @(posedge clk or posedge nrst) begin
            if (nrst) begin
                cnt_r <= '0;
            end else if (clear_s) begin
                cnt_r <= '0;
            end else if (fold_s) begin
                cnt_r <= sat_cnt(sum_s);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end
`else
    logic [HV_DIM-1:0] acc_r;
    logic [HV_DIM-1:0] lane_or_s;

    // OR of all lanes of the current beat.
    always_comb begin
        lane_or_s = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_or_s = lane_or_s | shifted_hv[l];
        end
    end

    assign result_s = acc_r | lane_or_s;

    // OR accumulator.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            acc_r <= '0;
        end else if (clear_s) begin
            acc_r <= '0;
        end else if (fold_s) begin
            acc_r <= result_s;
        end else begin
            acc_r <= acc_r;
        end
    end
`endif

    assign out_valid  = out_valid_r;
    assign busy       = busy_r;
    assign bundled_hv = bundled_r;

endmodule

// File: tb/tb_enc_bundler_acc.sv
// Directed bench for enc_bundler_acc (HV_DIM=128, LANES=2, NUM_PACKS=3).
module tb_enc_bundler_acc;

    localparam int HV = 128;
    localparam int LN = 2;
    localparam int NP = 3;

    logic          clk;
    logic          nrst;
    logic          start_encoding;
    logic          in_valid;
    logic [HV-1:0] shv [0:LN-1];
    logic          out_valid;
    logic          out_ready;
    logic [HV-1:0] bundled_hv;
    logic          busy;

    int total;
    int bad;
    logic [HV-1:0] exp_hv;

    enc_bundler_acc #(
        .HV_DIM    (HV),
        .LANES     (LN),
        .NUM_PACKS (NP)
`ifdef ENC_BUNDLE_THRESH_EN
        ,
        .CNT_W     (2),
        .THRESHOLD (2)
`endif
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .start_encoding (start_encoding),
        .in_valid       (in_valid),
        .shifted_hv     (shv),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .bundled_hv     (bundled_hv),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Threshold build: every listed bit goes to both lanes so it collects two votes.
    task automatic beat(input int a, input int b);
        shv[0] = '0;
        shv[1] = '0;
`ifdef ENC_BUNDLE_THRESH_EN
        if (a >= 0) begin shv[0][a] = 1'b1; shv[1][a] = 1'b1; end
        if (b >= 0) begin shv[0][b] = 1'b1; shv[1][b] = 1'b1; end
`else
        if (a >= 0) shv[0][a] = 1'b1;
        if (b >= 0) shv[1][b] = 1'b1;
`endif
    endtask

    task automatic ack();
        in_valid  = 1'b0;
        beat(-1, -1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (bundled_hv !== '0) begin bad++; $display("FAIL reset_bundled got=%h want=0", bundled_hv); end
        nrst = 1'b0;
        tick();
    endtask

    task automatic test_or_basic();
        start_encoding = 1'b1;
        tick();
        start_encoding = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
        in_valid = 1'b1;
        beat(0, 5);  tick();
        beat(5, 9);  tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", out_valid); end
        beat(100, -1); tick();
        in_valid = 1'b0;
        beat(-1, -1);
        exp_hv = '0; exp_hv[0] = 1'b1; exp_hv[5] = 1'b1; exp_hv[9] = 1'b1; exp_hv[100] = 1'b1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got=%b want=1", out_valid); end
        total++; if (bundled_hv !== exp_hv) begin bad++; $display("FAIL basic_bundled got=%h want=%h", bundled_hv, exp_hv); end
        ack();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_ack_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_ack_busy got=%b want=0", busy); end
    endtask

    task automatic test_stall();
        logic vld [6];
        int   a   [6];
        int   b   [6];
        vld = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        a   = '{0, 50, 70, 5, 77, 100};
        b   = '{5, 51, -1, 9, -1, -1};
        start_encoding = 1'b1;
        tick();
        start_encoding = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = vld[i];
            beat(a[i], b[i]);
            if (i == 5) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_early_valid got=%b want=0", out_valid); end
            end
            tick();
        end
        in_valid = 1'b0;
        beat(-1, -1);
        exp_hv = '0; exp_hv[0] = 1'b1; exp_hv[5] = 1'b1; exp_hv[9] = 1'b1; exp_hv[100] = 1'b1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid got=%b want=1", out_valid); end
        total++; if (bundled_hv !== exp_hv) begin bad++; $display("FAIL stall_bundled got=%h want=%h", bundled_hv, exp_hv); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            start_encoding = (i == 2);
            in_valid = 1'b1;
            beat(60, 61);
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid cyc=%0d got=%b want=1", i, out_valid); end
            total++; if (bundled_hv !== exp_hv) begin bad++; $display("FAIL hold_bundled cyc=%0d got=%h want=%h", i, bundled_hv, exp_hv); end
        end
        in_valid = 1'b0;
        beat(-1, -1);
        start_encoding = 1'b1;
        out_ready = 1'b1;
        tick();
        start_encoding = 1'b0;
        out_ready = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", busy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid got=%b want=0", out_valid); end
        in_valid = 1'b1;
        beat(1, -1); tick();
        beat(2, -1); tick();
        beat(3, -1); tick();
        in_valid = 1'b0;
        beat(-1, -1);
        exp_hv = '0; exp_hv[1] = 1'b1; exp_hv[2] = 1'b1; exp_hv[3] = 1'b1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_out_valid got=%b want=1", out_valid); end
        total++; if (bundled_hv !== exp_hv) begin bad++; $display("FAIL b2b_bundled got=%h want=%h", bundled_hv, exp_hv); end
        ack();
    endtask

    task automatic test_ignored();
        in_valid = 1'b1;
        beat(60, 61);
        tick();
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_valid_busy got=%b want=0", busy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid_out got=%b want=0", out_valid); end
        in_valid = 1'b0;
        start_encoding = 1'b1;
        tick();
        in_valid = 1'b1;
        start_encoding = 1'b0;
        beat(10, -1); tick();
        start_encoding = 1'b1;
        beat(11, -1); tick();
        start_encoding = 1'b0;
        beat(12, -1); tick();
        in_valid = 1'b0;
        beat(-1, -1);
        exp_hv = '0; exp_hv[10] = 1'b1; exp_hv[11] = 1'b1; exp_hv[12] = 1'b1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midstart_valid got=%b want=1", out_valid); end
        total++; if (bundled_hv !== exp_hv) begin bad++; $display("FAIL midstart_bundled got=%h want=%h", bundled_hv, exp_hv); end
        ack();
    endtask

    task automatic test_reset_mid();
        start_encoding = 1'b1;
        tick();
        start_encoding = 1'b0;
        in_valid = 1'b1;
        beat(3, -1); tick();
        beat(4, -1);
        #2;
        nrst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        total++; if (bundled_hv !== '0) begin bad++; $display("FAIL midrst_bundled got=%h want=0", bundled_hv); end
        tick();
        nrst = 1'b0;
        in_valid = 1'b0;
        beat(-1, -1);
        tick();
        start_encoding = 1'b1;
        tick();
        start_encoding = 1'b0;
        in_valid = 1'b1;
        beat(6, -1); tick();
        beat(7, -1); tick();
        beat(8, -1); tick();
        in_valid = 1'b0;
        beat(-1, -1);
        exp_hv = '0; exp_hv[6] = 1'b1; exp_hv[7] = 1'b1; exp_hv[8] = 1'b1;
        total++; if (bundled_hv !== exp_hv) begin bad++; $display("FAIL postrst_bundled got=%h want=%h", bundled_hv, exp_hv); end
        ack();
    endtask

`ifdef ENC_BUNDLE_THRESH_EN
    task automatic test_threshold();
        start_encoding = 1'b1;
        tick();
        start_encoding = 1'b0;
        in_valid = 1'b1;
        shv[0] = '0; shv[1] = '0; shv[0][7] = 1'b1; shv[1][7] = 1'b1; shv[0][9] = 1'b1; tick();
        shv[0] = '0; shv[1] = '0; shv[0][8] = 1'b1; tick();
        shv[0] = '0; shv[1] = '0; shv[1][9] = 1'b1; tick();
        in_valid = 1'b0;
        beat(-1, -1);
        total++; if (bundled_hv[7] !== 1'b1) begin bad++; $display("FAIL thr_bit7 got=%b want=1", bundled_hv[7]); end
        total++; if (bundled_hv[8] !== 1'b0) begin bad++; $display("FAIL thr_bit8 got=%b want=0", bundled_hv[8]); end
        total++; if (bundled_hv[9] !== 1'b1) begin bad++; $display("FAIL thr_bit9 got=%b want=1", bundled_hv[9]); end
        ack();
    endtask

    // Votes 2+2+1 on bit 20: a wrapping 2-bit counter would end at 1 and read 0.
    task automatic test_saturation();
        start_encoding = 1'b1;
        tick();
        start_encoding = 1'b0;
        in_valid = 1'b1;
        shv[0] = '0; shv[1] = '0; shv[0][20] = 1'b1; shv[1][20] = 1'b1; tick();
        tick();
        shv[1] = '0; tick();
        in_valid = 1'b0;
        beat(-1, -1);
        total++; if (bundled_hv[20] !== 1'b1) begin bad++; $display("FAIL sat_bit20 got=%b want=1", bundled_hv[20]); end
        ack();
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        nrst = 1'b1;
        start_encoding = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        beat(-1, -1);
        test_reset();
        test_or_basic();
        test_stall();
        test_back_to_back();
        test_ignored();
        test_reset_mid();
`ifdef ENC_BUNDLE_THRESH_EN
        test_threshold();
        test_saturation();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enc_bundler_acc.md
# enc_bundler_acc

Bundling stage directly downstream of the encoder binder packs. Each cycle it takes one pack of shifted (bound) level hypervectors, one per lane. Over a fixed number of packs it reduces them into a single sparse class/query hypervector. It then holds that result under a valid/ready handshake for the similarity stage.

## Interface
- HV_DIM, 1024: hypervector width in bits.
- LANES, FEATURES_PER_CC/2: hypervectors per input beat; equals the binder-pack lane count.
- NUM_PACKS, 10: beats per encoding.
- CNT_W, 8: per-bit counter width (threshold build only).
- THRESHOLD, 2: minimum per-bit vote count for a 1 (threshold build only).
- clk  in  1  system clock, rising edge.
- nrst  in  1  reset. One clock; reset is asynchronous and active-high.
- start_encoding  in  1  single-cycle pulse; same signal that drives the binder packs.
- in_valid  in  1  shifted_hv beat is valid this cycle.
- shifted_hv  in  HV_DIM x LANES (unpacked [0:LANES-1])  bound hypervectors of the current pack.
- out_valid  out  1  bundled_hv holds a completed result.
- out_ready  in  1  consumer accepts the result.
- bundled_hv  out  HV_DIM  bundled hypervector.
- busy  out  1  encoding in progress (state ≠ IDLE).

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE:
  - start_encoding=1 → clear accumulator and pack_cnt, go to ACCUM.
  - in_valid is ignored.
- ACCUM: each cycle with in_valid=1:
  - fold all LANES vectors into the accumulator;
  - pack_cnt++.
  - On the beat where pack_cnt==NUM_PACKS-1, register the result into bundled_hv and go to DONE.
  - in_valid=0 stalls; no timeout.
- DONE:
  - out_valid=1; bundled_hv stable.
  - out_valid && out_ready → IDLE.
  - in_valid is ignored.
- start_encoding outside IDLE is ignored.
  - Exception: in DONE in the same cycle as out_ready=1, the start is honored. Go directly to ACCUM with a cleared accumulator; back-to-back encodings lose no cycle.
- Fold rule, OR build: acc |= OR over lanes of shifted_hv[l].
- Fold rule, threshold build:
  - Per bit b: cnt[b] += popcount over lanes of shifted_hv[l][b].
  - cnt saturates at 2^CNT_W−1; it never wraps.
  - Result bit b = (cnt[b] + current-beat contribution ≥ THRESHOLD).
- pack_cnt width is clog2(NUM_PACKS), minimum 1.

## Timing
- Reset values:
  - state=IDLE, out_valid=0, busy=0;
  - bundled_hv=0, accumulator/counters=0, pack_cnt=0.
- Reset asserted mid-encoding aborts immediately; no partial result is ever flagged valid.
- Latency: out_valid rises the cycle after the last accepted beat. With continuous in_valid, start pulse to out_valid is NUM_PACKS+1 cycles.
- The first beat can be accepted the cycle after start_encoding. This matches the one-cycle registered output of the binders.
- bundled_hv changes only on the transition into DONE.

## Configuration
- Macro ENC_BUNDLE_THRESH_EN.
- Defined:
  - per-bit saturating counters of CNT_W bits;
  - thresholded majority-style bundling using THRESHOLD.
- Undefined:
  - counters and THRESHOLD/CNT_W logic are not built;
  - accumulator is a single HV_DIM register with OR bundling;
  - CNT_W and THRESHOLD are ignored.

## Structure
- Shared encoder package holds:
  - HV_DIM, FEATURES_PER_CC, NUM_PACKS;
  - state typedef enc_bund_state_t {IDLE, ACCUM, DONE};
  - the counter-width constant.
- One sub-module: enc_lane_popcount.
  - Combinational per-bit popcount of LANES input bits.
  - Instantiated HV_DIM times in the threshold build only.

## Test plan
- Basic OR build, NUM_PACKS=3, LANES=2. Beats set bits {0,5}, {5,9}, {100}. Expected: out_valid on the cycle after the 3rd beat; bundled_hv has exactly bits 0, 5, 9, 100 set.
- Threshold build, THRESHOLD=2. Bit 7 set in two lanes of one beat; bit 8 set once; bit 9 set in beat 1 and beat 3. Expected: bits 7 and 9 are 1, bit 8 is 0.
- Stalls: in_valid toggles 1,0,0,1,0,1 with NUM_PACKS=3. Expected: result equals the no-stall case; out_valid exactly 1 cycle after the 3rd valid beat.
- Backpressure and back-to-back:
  - hold out_ready=0 for 5 cycles → bundled_hv and out_valid stable;
  - assert out_ready together with start_encoding → ACCUM next cycle, the next result is independent of the previous one.
- Ignored events:
  - start_encoding mid-ACCUM → count not restarted;
  - in_valid in IDLE → no state change, accumulator stays 0.
- Reset and saturation:
  - nrst=1 during beat 2 → out_valid=0 and bundled_hv=0 immediately;
  - CNT_W=2 with one bit set in 6 beats → counter saturates at 3, no wrap, bit reads 1.
